// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared sequencer states, opcodes and datapath select encodings
package riscv_ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BEQ, S_JAL, S_TRAP
   } state_t;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [2:0] F3_ZERO   = 3'b000;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;
   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;
   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_MEM_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;
endpackage

// File: rtl/opcode_classify.sv
// opcode_classify: maps opcode/funct3 to the state that follows DECODE
module opcode_classify
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output state_t     next,
   output logic       illegal
);
   assign illegal = !(opcode inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL} ||
                      (opcode == OP_BRANCH && funct3 == F3_ZERO));
   assign next = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADR :
                 opcode == OP_R   ? S_EXEC_R :
                 opcode == OP_I   ? S_EXEC_I :
                 opcode == OP_JAL ? S_JAL    : S_BEQ;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RV32I sequencer driving datapath selects and strobes
module multicycle_control
   import riscv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        adr_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  result_src,
   output logic        illegal_instr,
   output logic        instr_done
);
   state_t state, next, dec_next;
   logic   dec_illegal, unused_bits;
   assign unused_bits = ^{instruction[31:15], instruction[11:7]};
   opcode_classify u_classify (
      .opcode (instruction[6:0]),
      .funct3 (instruction[14:12]),
      .next   (dec_next),
      .illegal(dec_illegal)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_FETCH;
      else        state <= next;
   // Outputs stay at 0 for the whole time rst_n is low, not just after the edge.
   always_comb begin
      next          = state;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      adr_src       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALU_ADD;
      result_src    = RES_ALU_OUT;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      if (rst_n)
         case (state)
            S_FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = SRC_B_FOUR;
               result_src = RES_ALU_RESULT;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
               next       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_a = SRC_A_OLD_PC;
               alu_src_b = SRC_B_IMM;
               next      = dec_illegal ? S_TRAP : dec_next;
            end
            S_MEM_ADR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               next      = instruction[6:0] == OP_STORE ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               adr_src  = 1'b1;
               next     = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               result_src = RES_MEM_DATA;
               instr_done = 1'b1;
               next       = S_FETCH;
            end
            S_MEM_WR: begin
               mem_write  = 1'b1;
               adr_src    = 1'b1;
               instr_done = mem_ready;
               next       = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALU_FUNCT;
               next      = S_ALU_WB;
            end
            // addi must stay ADD even when imm[10] looks like funct7[5]
            S_EXEC_I: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = instruction[14:12] == F3_ZERO ? ALU_ADD : ALU_FUNCT;
               next      = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               next       = S_FETCH;
            end
            S_BEQ: begin
               alu_src_a  = SRC_A_RS1;
               alu_op     = ALU_SUB;
               pc_write   = zero;
               instr_done = 1'b1;
               next       = S_FETCH;
            end
            S_JAL: begin
               alu_src_a = SRC_A_OLD_PC;
               alu_src_b = SRC_B_FOUR;
               pc_write  = 1'b1;
               next      = S_ALU_WB;
            end
            S_TRAP: begin
               illegal_instr = 1'b1;
               instr_done    = 1'b1;
               next          = S_FETCH;
            end
            default: next = S_FETCH;
         endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving instruction sequences against a phase-table model
module tb_multicycle_control;
   logic        clk = 0, rst_n = 0, zero = 0, mem_ready = 0;
   logic [31:0] instruction = 0;
   logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal_instr, instr_done;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   int          nvec = 0, nerr = 0;

   typedef struct { logic [15:0] v; int ph; } exp_t;
   exp_t exp_q[$];

   localparam int P_RST = -1, P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                  P_ER = 6, P_EI = 7, P_AW = 8, P_BQ = 9, P_J = 10, P_T = 11;
   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .illegal_instr(illegal_instr), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   // Expected control word for one cycle of a named instruction phase.
   function automatic logic [15:0] vec(input int p, input bit r, input bit z, input bit f3z);
      logic pcw = 0, irw = 0, adr = 0, mr = 0, mw = 0, rw = 0, ill = 0, dn = 0;
      logic [1:0] a = 0, b = 0, op = 0, res = 0;
      case (p)
         P_F:   begin mr = 1; b = 2'b10; res = 2'b10; pcw = r; irw = r; end
         P_D:   begin a = 2'b01; b = 2'b01; end
         P_MA:  begin a = 2'b10; b = 2'b01; end
         P_MR:  begin mr = 1; adr = 1; end
         P_MWB: begin rw = 1; res = 2'b01; dn = 1; end
         P_MW:  begin mw = 1; adr = 1; dn = r; end
         P_ER:  begin a = 2'b10; op = 2'b10; end
         P_EI:  begin a = 2'b10; b = 2'b01; op = f3z ? 2'b00 : 2'b10; end
         P_AW:  begin rw = 1; dn = 1; end
         P_BQ:  begin a = 2'b10; op = 2'b01; pcw = z; dn = 1; end
         P_J:   begin a = 2'b01; b = 2'b10; pcw = 1; end
         P_T:   begin ill = 1; dn = 1; end
         default: ;
      endcase
      return {pcw, irw, adr, mr, mw, rw, a, b, op, res, ill, dn};
   endfunction

   function automatic bit legal_op(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
   endfunction

   function automatic logic [31:0] mk(input int cls);
      logic [31:0] w = $urandom;
      logic [6:0]  op;
      case (cls)
         C_LW:  w[6:0] = 7'b0000011;
         C_SW:  w[6:0] = 7'b0100011;
         C_R:   w[6:0] = 7'b0110011;
         C_I:   w[6:0] = 7'b0010011;
         C_BEQ: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
         C_JAL: w[6:0] = 7'b1101111;
         default:
            if ($urandom_range(0, 1) == 1) begin
               w[6:0] = 7'b1100011;
               w[14:12] = 3'($urandom_range(1, 7));
            end else begin
               op = 7'($urandom);
               while (legal_op(op)) op = 7'($urandom);
               w[6:0] = op;
            end
      endcase
      return w;
   endfunction

   // lows >= 0: each memory-wait phase sees that many mem_ready-low cycles; lows < 0: random.
   task automatic run_instr(input logic [31:0] ins, input int cls, input int lows, input int zm, input bit abort);
      int ph[$];
      int n;
      bit busy, w, r, z, f3z;
      f3z = ins[14:12] == 3'b000;
      case (cls)
         C_LW:    ph = '{P_F, P_D, P_MA, P_MR, P_MWB};
         C_SW:    ph = '{P_F, P_D, P_MA, P_MW};
         C_R:     ph = '{P_F, P_D, P_ER, P_AW};
         C_I:     ph = '{P_F, P_D, P_EI, P_AW};
         C_BEQ:   ph = '{P_F, P_D, P_BQ};
         C_JAL:   ph = '{P_F, P_D, P_J, P_AW};
         default: ph = '{P_F, P_D, P_T};
      endcase
      foreach (ph[k]) begin
         n = 0;
         busy = 1;
         while (busy) begin
            w = ph[k] == P_F || ph[k] == P_MR || ph[k] == P_MW;
            r = !w ? 1'($urandom_range(0, 1)) : lows < 0 ? ($urandom_range(0, 3) != 0) : (n >= lows);
            if (abort && ph[k] == P_MW) r = 0;
            z = zm < 0 ? 1'($urandom_range(0, 1)) : zm[0];
            @(negedge clk);
            instruction = ins; mem_ready = r; zero = z;
            exp_q.push_back('{vec(ph[k], r, z, f3z), ph[k]});
            n++;
            busy = w && !r;
            if (abort && ph[k] == P_MW && n == 3) return;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rst_n = 0; mem_ready = 1'($urandom); zero = 1'($urandom); instruction = $urandom;
         exp_q.push_back('{16'h0, P_RST});
      end
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial forever begin
      exp_t e;
      logic [15:0] got;
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         got = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, instr_done};
         nvec++;
         if (got !== e.v) begin
            nerr++;
            $display("FAIL ctrl phase=%0d t=%0t got=%04h exp=%04h", e.ph, $time, got, e.v);
         end
      end
   end

   initial begin
      int cls;
      do_reset(3);
      run_instr(32'h002081B3, C_R,   2,  -1, 0);
      run_instr(32'hFFF00093, C_I,   0,  -1, 0);
      run_instr(32'h4020D093, C_I,   0,  -1, 0);
      run_instr(32'h00402283, C_LW,  0,  -1, 0);
      run_instr(32'h00112223, C_SW,  2,  -1, 0);
      run_instr(32'h00208063, C_BEQ, 0,   1, 0);
      run_instr(32'h00208063, C_BEQ, 0,   0, 0);
      run_instr(32'h0040006F, C_JAL, 1,  -1, 0);
      run_instr(32'h0000007F, C_ILL, 0,  -1, 0);
      run_instr(32'h00112223, C_SW,  0,  -1, 1);
      do_reset(2);
      run_instr(32'h002081B3, C_R,   0,  -1, 0);
      for (int i = 0; i < 300; i++) begin
         cls = $urandom_range(0, 6);
         run_instr(mk(cls), cls, -1, -1, 0);
         if ($urandom_range(0, 40) == 0) do_reset(1);
      end
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
